// File: rtl/mult_pkg.sv
// Shared definitions for the multiply sequencer and its datapath partner:
// FSM state encoding, multiplier select commands and operand width.
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int CNT_WIDTH  = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_STEP    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

  localparam logic [1:0] SEL_LOAD = 2'b00;
  localparam logic [1:0] SEL_STEP = 2'b01;
  localparam logic [1:0] SEL_HOLD = 2'b10;

endpackage

// File: rtl/mult_sequencer.sv
// Drives the iterative multiplier through load + MULT_STEPS shift-add steps,
// captures the product into HI/LO and handles direct HI/LO writes.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int MULT_STEPS = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [MULT_WIDTH-1:0] op_a,
  input  logic [MULT_WIDTH-1:0] op_b,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [MULT_WIDTH-1:0] wdata,
  input  logic [MULT_WIDTH-1:0] mult_product0,
  input  logic [MULT_WIDTH-1:0] mult_product1,
  output logic [MULT_WIDTH-1:0] mult_multiplier,
  output logic [MULT_WIDTH-1:0] mult_multiplicand,
  output logic [1:0]            mult_select,
  output logic [MULT_WIDTH-1:0] hi,
  output logic [MULT_WIDTH-1:0] lo,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(MULT_STEPS - 1);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [MULT_WIDTH-1:0] a_q, a_d;
  logic [MULT_WIDTH-1:0] b_q, b_d;
  logic [MULT_WIDTH-1:0] hi_q, hi_d;
  logic [MULT_WIDTH-1:0] lo_q, lo_d;
  logic [1:0]            sel_q, sel_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Select, busy and done are computed for the state being entered, so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path through
    // this block leaves a value unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        sel_d = SEL_HOLD;
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          state_d = ST_LOAD;
          sel_d   = SEL_LOAD;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_STEP;
        sel_d   = SEL_STEP;
      end
      ST_STEP: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = ST_CAPTURE;
          sel_d   = SEL_HOLD;
        end
      end
      ST_CAPTURE: begin
        // Product is final: the last step happened on the edge entering CAPTURE.
        hi_d    = mult_product1;
        lo_d    = mult_product0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        sel_d   = SEL_HOLD;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = SEL_HOLD;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sel_q   <= SEL_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mult_multiplier   = a_q;
  assign mult_multiplicand = b_q;
  assign mult_select       = sel_q;
  assign hi                = hi_q;
  assign lo                = lo_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural signed iterative
// multiplier that only presents a valid product after exactly 32 steps.
module tb_mult_sequencer;
  import mult_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] wdata = '0;
  logic [31:0] mult_product0, mult_product1;
  logic [31:0] mult_multiplier, mult_multiplicand;
  logic [1:0]  mult_select;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_sequencer #(.MULT_STEPS(32)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .op_a             (op_a),
    .op_b             (op_b),
    .hi_we            (hi_we),
    .lo_we            (lo_we),
    .wdata            (wdata),
    .mult_product0    (mult_product0),
    .mult_product1    (mult_product1),
    .mult_multiplier  (mult_multiplier),
    .mult_multiplicand(mult_multiplicand),
    .mult_select      (mult_select),
    .hi               (hi),
    .lo               (lo),
    .busy             (busy),
    .done             (done)
  );

  // Multiplier stand-in: no reset, loads on select 00, steps on 01. Output is
  // garbage unless exactly 32 steps have elapsed since the last load.
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  int          m_cnt = 0;
  logic [63:0] m_prod;

  assign m_prod = $signed({{32{m_a[31]}}, m_a}) * $signed({{32{m_b[31]}}, m_b});
  assign mult_product0 = (m_cnt == 32) ? m_prod[31:0]  : (32'hBAD0_0000 | 32'(m_cnt));
  assign mult_product1 = (m_cnt == 32) ? m_prod[63:32] : (32'hBAD1_0000 | 32'(m_cnt));

  always @(posedge clk) begin
    case (mult_select)
      2'b00: begin
        m_a   <= mult_multiplier;
        m_b   <= mult_multiplicand;
        m_cnt <= 0;
      end
      2'b01: if (m_cnt < 40) m_cnt <= m_cnt + 1;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Applies start for one edge (E0); returns at the negedge inside E0-E1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic wr_lo);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    lo_we = wr_lo;
    wdata = 32'h0000_CAFE;
    @(negedge clk);
    start = 1'b0;
    lo_we = 1'b0;
    check("latch_op_a", 64'(mult_multiplier), 64'(a));
    check("latch_op_b", 64'(mult_multiplicand), 64'(b));
    if (wr_lo) check("write_with_start", 64'(lo), 64'h0000_CAFE);
  endtask

  // Called in cycle E0-E1. Samples each cycle until done; lat is the edge
  // index E_k after which done was first seen (-1 on timeout).
  task automatic monitor(input int pulse_at, input int we_at, output int lat,
                         output int n_load, output int n_step,
                         output logic [1:0] first_sel, output int busy_err);
    logic [31:0] hi_snap;
    hi_snap   = hi;
    lat       = -1;
    n_load    = 0;
    n_step    = 0;
    busy_err  = 0;
    first_sel = mult_select;
    for (int k = 1; k <= 60; k++) begin
      if (mult_select == SEL_LOAD) n_load++;
      else if (mult_select == SEL_STEP) n_step++;
      if (!busy) busy_err++;
      if (k == pulse_at) start = 1'b1;
      else if (pulse_at > 0) start = 1'b0;
      if (k == we_at) begin
        hi_we = 1'b1;
        wdata = 32'h1234_5678;
      end else begin
        hi_we = 1'b0;
      end
      if (we_at > 0 && k == we_at + 1) check("hi_we_ignored_in_step", 64'(hi), 64'(hi_snap));
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic mult_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic wr_lo, input int pulse_at, input int we_at);
    int lat, n_load, n_step, busy_err;
    logic [1:0] first_sel;
    issue(a, b, wr_lo);
    monitor(pulse_at, we_at, lat, n_load, n_step, first_sel, busy_err);
    check("latency", 64'(lat), 64'd34);
    check("first_sel_load", 64'(first_sel), 64'(SEL_LOAD));
    check("load_count", 64'(n_load), 64'd1);
    check("step_count", 64'(n_step), 64'd32);
    check("busy_while_active", 64'(busy_err), 64'd0);
    check("hi_result", 64'(hi), 64'(exp_hi));
    check("lo_result", 64'(lo), 64'(exp_lo));
    check("busy_low_in_done", 64'(busy), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("sel_hold_idle", 64'(mult_select), 64'(SEL_HOLD));
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, n_load, n_step, busy_err;
    logic [1:0] first_sel;

    // Reset values
    #12;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_sel", 64'(mult_select), 64'(SEL_HOLD));
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mplier", 64'(mult_multiplier), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 3 x 5
    mult_op(32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 1'b0, 0, 0);

    // Direct writes in IDLE
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b1;
    wdata = 32'h0BAD_F00D;
    check("hi_write_idle", 64'(hi), 64'hDEAD_BEEF);
    @(negedge clk);
    lo_we = 1'b0;
    check("lo_write_idle", 64'(lo), 64'h0BAD_F00D);
    check("hi_kept_on_lo_write", 64'(hi), 64'hDEAD_BEEF);

    // -2 x 3 with a hi write attempted during STEP
    mult_op(32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 0, 5);

    // Asynchronous reset at step 10 of 7 x 6
    issue(32'd7, 32'd6, 1'b0);
    repeat (11) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    check("pre_rst_sel", 64'(mult_select), 64'(SEL_STEP));
    #2 reset_n = 1'b0;
    #1;
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_sel", 64'(mult_select), 64'(SEL_HOLD));
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_mplier", 64'(mult_multiplier), 64'd0);
    check("arst_mcand", 64'(mult_multiplicand), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mult_op(32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 0, 0);

    // -1 x -1 with a simultaneous lo write and a stray start in STEP cycle 10
    mult_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1, 11, 0);
    check("stray_start_ignored_busy", 64'(busy), 64'd0);

    // start tied high: back-to-back every 35 cycles
    @(negedge clk);
    op_a  = 32'h0001_0000;
    op_b  = 32'h0001_0000;
    start = 1'b1;
    @(negedge clk);
    monitor(0, 0, lat, n_load, n_step, first_sel, busy_err);
    check("b2b1_latency", 64'(lat), 64'd34);
    check("b2b1_steps", 64'(n_step), 64'd32);
    check("b2b1_idle_in_done_sel", 64'(mult_select), 64'(SEL_HOLD));
    check("b2b1_idle_in_done_busy", 64'(busy), 64'd0);
    check("b2b1_hi", 64'(hi), 64'd1);
    check("b2b1_lo", 64'(lo), 64'd0);
    op_a = 32'h7FFF_FFFF;
    op_b = 32'h0000_0002;
    @(negedge clk);
    check("b2b2_latched", 64'(mult_multiplier), 64'h7FFF_FFFF);
    monitor(0, 0, lat, n_load, n_step, first_sel, busy_err);
    check("b2b2_period", 64'(lat + 1), 64'd35);
    check("b2b2_load_immediate", 64'(first_sel), 64'(SEL_LOAD));
    check("b2b2_steps", 64'(n_step), 64'd32);
    check("b2b2_busy", 64'(busy_err), 64'd0);
    check("b2b2_hi", 64'(hi), 64'd0);
    check("b2b2_lo", 64'(lo), 64'hFFFF_FFFE);
    start = 1'b0;
    @(negedge clk);
    check("b2b_stop_sel", 64'(mult_select), 64'(SEL_HOLD));
    check("b2b_stop_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Control and result stage directly upstream/downstream of the iterative `Multiplier` datapath. It accepts a multiply request with two 32-bit operands and drives the multiplier's `select` port through the load step and 32 shift-add steps. It captures the 64-bit product into architectural HI/LO registers and signals completion. HI/LO are also directly writable for move-to-HI/LO instructions.

## Interface
- `MULT_STEPS`, default 32: number of step cycles issued after load; must equal the multiplier operand width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `op_a`  in  32  multiplier operand, latched on accepted `start`.
- `op_b`  in  32  multiplicand operand, latched on accepted `start`.
- `hi_we`, `lo_we`  in  1  direct write enables for HI/LO; honoured only when not busy.
- `wdata`  in  32  data for direct HI/LO writes.
- `mult_product0`  in  32  multiplier low product word.
- `mult_product1`  in  32  multiplier high product word.
- `mult_multiplier`  out  32  latched `op_a` to the multiplier.
- `mult_multiplicand`  out  32  latched `op_b` to the multiplier.
- `mult_select`  out  2  multiplier command: 00 load, 01 step, 10 hold.
- `hi`, `lo`  out  32  architectural HI/LO registers.
- `busy`  out  1  high from the cycle after accepted `start` through CAPTURE.
- `done`  out  1  one-cycle pulse; HI/LO already hold the new product in that cycle.

## Operation
- States: IDLE, LOAD, STEP, CAPTURE.
- **IDLE**
  - `mult_select` = 10.
  - `start` = 1 latches `op_a`/`op_b` and moves to LOAD.
- **LOAD**
  - Lasts one cycle with `mult_select` = 00.
  - Clears the step counter and moves to STEP.
- **STEP**
  - `mult_select` = 01 for exactly `MULT_STEPS` cycles.
  - A 6-bit counter increments each cycle.
  - Moves to CAPTURE when the counter reaches `MULT_STEPS`-1 in the current cycle.
- **CAPTURE**
  - `mult_select` = 10.
  - `hi` <= `mult_product1`, `lo` <= `mult_product0`.
  - Asserts `done` next cycle and returns to IDLE.
- Operand latches hold stable from LOAD through CAPTURE; the multiplier reads them at its load edge.
- Signedness is the multiplier's concern; the sequencer is sign-agnostic.
- Direct writes:
  - `hi_we` or `lo_we` in IDLE writes `wdata` at the next edge.
  - Writes are ignored in LOAD, STEP and CAPTURE.
  - Simultaneous write and `start` in IDLE: the write is applied, and `start` is also accepted. The later CAPTURE overwrites the written value.
- `start` outside IDLE is ignored, with no queuing.
- `start` held high continuously: a new operation is accepted in the same cycle `done` is high (state is IDLE then).

## Timing
- Reset values: state IDLE, `hi` = 0, `lo` = 0, operand latches 0, `mult_select` = 10, `busy` = 0, `done` = 0, counter 0.
- Reset takes effect immediately, including mid-operation.
- The multiplier has no reset, so its internal state is stale after a reset. The next LOAD fully reinitialises it; no extra handling is required.
- Cycle numbering, with `start` sampled at edge E0:
  - LOAD occupies E0–E1; the multiplier loads at E1.
  - STEP occupies E1–E33; the multiplier steps at E2..E33.
  - CAPTURE occupies E33–E34; HI/LO update at E34.
  - `done` is high in E34–E35.
- Latency: `start` edge to `done` = `MULT_STEPS` + 2 cycles (34).
- Throughput: one multiply per 35 cycles when back-to-back (IDLE/`done` cycle included).
- `busy` rises after E0 and falls at E34, so it is low in the `done` cycle.

## Structure
- Shared package `mult_pkg` holds:
  - state encoding (IDLE/LOAD/STEP/CAPTURE);
  - select constants `SEL_LOAD` = 2'b00, `SEL_STEP` = 2'b01, `SEL_HOLD` = 2'b10;
  - `MULT_WIDTH` = 32.
- No sub-module is required. FSM, counter and HI/LO registers live in one module.
- The `Multiplier` is instantiated at the parent level alongside this block.

## Test plan
- 3 × 5 (signed multiplier): `done` exactly 34 cycles after the `start` edge; `hi` = 0x00000000, `lo` = 0x0000000F; `mult_select` shows one 00 then exactly 32 × 01.
- 0xFFFFFFFE × 0x00000003 (−2 × 3): `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFFA.
- 0xFFFFFFFF × 0xFFFFFFFF: `hi` = 0, `lo` = 1. Then `start` pulsed at cycle 10 of STEP is ignored, and the completion time is unchanged.
- `hi_we` with `wdata` = 0xDEADBEEF in IDLE gives `hi` = 0xDEADBEEF. The same write during STEP leaves `hi` unchanged until CAPTURE.
- `reset_n` low at step 10 of 7 × 6: outputs go to reset values asynchronously. A new 7 × 6 after release yields `lo` = 42, `hi` = 0 at the 34-cycle latency.
- `start` tied high: back-to-back operations every 35 cycles. Each `done` coincides with IDLE, and the next LOAD follows immediately.
